multicycle_control: RTL and testbench

Multi-cycle MIPS control unit. It is the sequential successor to the single-cycle opcode/funct decoder. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath strobes and mux selects in every state. It handshakes with a variable-latency memory, traps on illegal instructions and memory timeouts, and counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control unit and the IR/datapath:
// instruction fields and memory handshake in, strobes and selects out.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       state;
    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             ext_op;
    logic             lu_op;
    logic [3:0]       alu_op;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic             illegal;
    logic             timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output state, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               ext_op, lu_op, alu_op, instr_done, instr_count, illegal, timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  state, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               ext_op, lu_op, alu_op, instr_done, instr_count, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake, illegal/timeout traps and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_count;
    logic               r_illegal;
    logic               r_timeout;

    logic w_rtype, w_r_ok, w_shift, w_jr, w_jalr;
    logic w_j, w_jal, w_beq, w_itype, w_lw, w_sw, w_legal;
    logic w_mem_expire;
    logic [3:0] w_alu_dec;

    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write, w_reg_write;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_a, w_alu_src_b, w_pc_src;
    logic [3:0] w_alu_op;
    logic       w_done;

    always_comb begin
        w_rtype = (bus.opcode == 6'h00);
        w_r_ok  = bus.funct inside {[6'h20:6'h27], 6'h2a, 6'h2b, 6'h00, 6'h02,
                                    6'h03, 6'h08, 6'h09};
        w_shift = w_rtype && (bus.funct inside {6'h00, 6'h02, 6'h03});
        w_jr    = w_rtype && (bus.funct == 6'h08);
        w_jalr  = w_rtype && (bus.funct == 6'h09);
        w_j     = (bus.opcode == 6'h02);
        w_jal   = (bus.opcode == 6'h03);
        w_beq   = (bus.opcode == 6'h04);
        w_itype = bus.opcode inside {[6'h08:6'h0c], 6'h0f};
        w_lw    = (bus.opcode == 6'h23);
        w_sw    = (bus.opcode == 6'h2b);
        w_legal = (w_rtype && w_r_ok) || w_j || w_jal || w_beq || w_itype || w_lw || w_sw;

        w_alu_dec[3] = bus.opcode[0];
        if (w_rtype)                        w_alu_dec[2:0] = 3'b010;
        else if (w_beq)                     w_alu_dec[2:0] = 3'b001;
        else if (bus.opcode == 6'h0c)       w_alu_dec[2:0] = 3'b100;
        else if (bus.opcode inside {6'h0a, 6'h0b}) w_alu_dec[2:0] = 3'b101;
        else                                w_alu_dec[2:0] = 3'b000;

        // The limit cycle traps only if mem_ready is still low in it
        w_mem_expire = (MEM_TIMEOUT != 0) && !bus.mem_ready && (r_wait == WAIT_LAST);
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = '0;
        w_mem_to_reg = '0;
        w_alu_src_a  = '0;
        w_alu_src_b  = '0;
        w_pc_src     = '0;
        w_alu_op     = '0;
        w_done       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_alu_src_b = 2'b01;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                if (w_j || w_jal) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'b01;
                    w_done     = 1'b1;
                    if (w_jal) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'b10;
                        w_mem_to_reg = 2'b10;
                    end
                end
            end
            S_EXEC: begin
                if (w_lw || w_sw) begin
                    w_alu_src_a = 2'b01;
                    w_alu_src_b = 2'b10;
                end else begin
                    w_alu_op = w_alu_dec;
                    if (w_beq) begin
                        w_alu_src_a = 2'b01;
                        w_done      = 1'b1;
                        if (bus.zero) begin
                            w_pc_write = 1'b1;
                            w_pc_src   = 2'b10;
                        end
                    end else if (w_jr || w_jalr) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'b11;
                        w_done     = 1'b1;
                        if (w_jalr) begin
                            w_reg_write  = 1'b1;
                            w_reg_dst    = 2'b01;
                            w_mem_to_reg = 2'b10;
                        end
                    end else if (w_rtype) begin
                        w_alu_src_a = w_shift ? 2'b10 : 2'b01;
                    end else begin
                        w_alu_src_a = 2'b01;
                        w_alu_src_b = 2'b10;
                    end
                end
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_mem_read  = w_lw;
                w_mem_write = w_sw;
                w_done      = w_sw && bus.mem_ready;
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                if (w_lw)         w_mem_to_reg = 2'b01;
                else if (w_rtype) w_reg_dst    = 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // Wait counter restarts whenever FETCH/MEM is (re)entered
            r_wait <= '0;
            if (w_done) r_count <= r_count + CNT_W'(1);
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_mem_expire) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else if (w_j || w_jal) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_lw || w_sw)                r_state <= S_MEM;
                    else if (w_beq || w_jr || w_jalr) r_state <= S_FETCH;
                    else                             r_state <= S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= w_lw ? S_WB : S_FETCH;
                    end else if (w_mem_expire) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Strobes drop combinationally with reset so an aborted access never leaks
    assign bus.pc_write    = reset_n & w_pc_write;
    assign bus.ir_write    = reset_n & w_ir_write;
    assign bus.iord        = reset_n & w_iord;
    assign bus.mem_read    = reset_n & w_mem_read;
    assign bus.mem_write   = reset_n & w_mem_write;
    assign bus.reg_write   = reset_n & w_reg_write;
    assign bus.instr_done  = reset_n & w_done;
    assign bus.reg_dst     = {2{reset_n}} & w_reg_dst;
    assign bus.mem_to_reg  = {2{reset_n}} & w_mem_to_reg;
    assign bus.alu_src_a   = {2{reset_n}} & w_alu_src_a;
    assign bus.alu_src_b   = {2{reset_n}} & w_alu_src_b;
    assign bus.pc_src      = {2{reset_n}} & w_pc_src;
    assign bus.alu_op      = {4{reset_n}} & w_alu_op;
    assign bus.ext_op      = (bus.opcode != 6'h0c);
    assign bus.lu_op       = (bus.opcode == 6'h0f);
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;
    assign bus.illegal     = r_illegal;
    assign bus.timeout     = r_timeout;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its expected per-cycle control words and compared cycle by cycle.
module tb_multicycle_control;
    localparam int unsigned TMO = 4;
    localparam logic [2:0] S_FE = 3'd0, S_DE = 3'd1, S_EX = 3'd2,
                           S_ME = 3'd3, S_WB = 3'd4, S_TR = 3'd5;

    typedef enum {K_R, K_SH, K_JR, K_JALR, K_J, K_JAL, K_BEQ, K_I, K_LW, K_SW, K_ILL} kind_t;

    typedef struct {
        logic [2:0]  st;
        logic        rdy;
        logic        z;
        logic [20:0] ctl;
        int          cause;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) bus();

    multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cyc_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_count  = 0;
    logic        m_ill    = 1'b0;
    logic        m_tmo    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] mk(input logic pcw, irw, io, mr, mw, rw,
                                       input logic [1:0] rd, m2r, a, b, ps,
                                       input logic [3:0] aop, input logic dn);
        return {pcw, irw, io, mr, mw, rw, rd, m2r, a, b, ps, aop, dn};
    endfunction

    function automatic logic [20:0] got_ctl();
        return {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.pc_src, bus.alu_op, bus.instr_done};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03: return K_SH;
                6'h08: return K_JR;
                6'h09: return K_JALR;
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h2b: return K_R;
                default: return K_ILL;
            endcase
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return K_I;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] iop(input logic [5:0] op);
        case (op)
            6'h09, 6'h0f: return 4'b1000;
            6'h0a:        return 4'b0101;
            6'h0b:        return 4'b1101;
            6'h0c:        return 4'b0100;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input logic rdy, input logic z,
                                 input logic [20:0] ctl, input int cause);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.z = z; c.ctl = ctl; c.cause = cause;
        q.push_back(c);
    endfunction

    function automatic void tail();
        repeat (20) push(S_TR, rb(), rb(), '0, 0);
    endfunction

    // Expected cycle sequence for one instruction; returns 1 if it ends in TRAP.
    function automatic bit plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int unsigned wf, input int unsigned wm);
        kind_t k = classify(op, fn);
        logic  lw = (k == K_LW);
        for (int unsigned i = 0; i < wf; i++) begin
            push(S_FE, 1'b0, rb(), mk(0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 4'h0, 0),
                 (i == TMO - 1) ? 2 : 0);
            if (i == TMO - 1) begin tail(); return 1'b1; end
        end
        push(S_FE, 1'b1, rb(), mk(1,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 4'h0, 0), 0);
        case (k)
            K_ILL: begin
                push(S_DE, rb(), rb(), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11,2'b00, 4'h0, 0), 1);
                tail();
                return 1'b1;
            end
            K_J: begin
                push(S_DE, rb(), rb(), mk(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11,2'b01, 4'h0, 1), 0);
                return 1'b0;
            end
            K_JAL: begin
                push(S_DE, rb(), rb(), mk(1,0,0,0,0,1, 2'b10,2'b10,2'b00,2'b11,2'b01, 4'h0, 1), 0);
                return 1'b0;
            end
            default: push(S_DE, rb(), rb(), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11,2'b00, 4'h0, 0), 0);
        endcase
        case (k)
            K_BEQ: push(S_EX, rb(), z, mk(z,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,
                                          z ? 2'b10 : 2'b00, 4'b0001, 1), 0);
            K_JR:   push(S_EX, rb(), rb(), mk(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11, 4'b0010, 1), 0);
            K_JALR: push(S_EX, rb(), rb(), mk(1,0,0,0,0,1, 2'b01,2'b10,2'b00,2'b00,2'b11, 4'b0010, 1), 0);
            K_R, K_SH: begin
                push(S_EX, rb(), rb(), mk(0,0,0,0,0,0, 2'b00,2'b00, (k == K_SH) ? 2'b10 : 2'b01,
                                          2'b00,2'b00, 4'b0010, 0), 0);
                push(S_WB, rb(), rb(), mk(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 4'h0, 1), 0);
            end
            K_I: begin
                push(S_EX, rb(), rb(), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00, iop(op), 0), 0);
                push(S_WB, rb(), rb(), mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 4'h0, 1), 0);
            end
            K_LW, K_SW: begin
                push(S_EX, rb(), rb(), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00, 4'h0, 0), 0);
                for (int unsigned i = 0; i < wm; i++) begin
                    push(S_ME, 1'b0, rb(), mk(0,0,1,lw,!lw,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 4'h0, 0),
                         (i == TMO - 1) ? 2 : 0);
                    if (i == TMO - 1) begin tail(); return 1'b1; end
                end
                push(S_ME, 1'b1, rb(), mk(0,0,1,lw,!lw,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 4'h0, !lw), 0);
                if (lw)
                    push(S_WB, rb(), rb(), mk(0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00,2'b00, 4'h0, 1), 0);
            end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic step(input cyc_t c, input logic [5:0] op, input logic [5:0] fn);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = c.z;
        bus.mem_ready = c.rdy;
        @(negedge clk);
        chk("state",   32'(bus.state), 32'(c.st));
        chk("ctl",     32'(got_ctl()), 32'(c.ctl));
        chk("count",   bus.instr_count, m_count);
        chk("illegal", 32'(bus.illegal), 32'(m_ill));
        chk("timeout", 32'(bus.timeout), 32'(m_tmo));
        chk("ext_op",  32'(bus.ext_op), 32'(op != 6'h0c));
        chk("lu_op",   32'(bus.lu_op), 32'(op == 6'h0f));
        @(posedge clk);
        #1;
        if (c.ctl[0]) m_count++;
        if (c.cause == 1) m_ill = 1'b1;
        if (c.cause == 2) m_tmo = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state), 32'(S_FE));
        chk("rst_ctl",   32'(got_ctl()), 32'h0);
        chk("rst_count", bus.instr_count, 32'h0);
        chk("rst_flags", 32'({bus.illegal, bus.timeout}), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_count = 0;
        m_ill   = 1'b0;
        m_tmo   = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int unsigned wf, input int unsigned wm);
        bit trapped;
        trapped = plan(op, fn, z, wf, wm);
        while (q.size() > 0) step(q.pop_front(), op, fn);
        if (trapped) do_reset();
    endtask

    function automatic int unsigned rwait();
        return ($urandom_range(0, 11) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 3);
    endfunction

    initial begin
        logic [5:0] op, fn;
        logic [5:0] rfn[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
        logic [5:0] iops[6] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(6'h00, 6'h21, 1'b0, 0, 0);   // addu
        run_instr(6'h23, 6'h15, 1'b0, 0, 3);   // lw, 3 wait cycles in MEM
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal -> trap
        run_instr(6'h00, 6'h21, 1'b0, TMO, 0); // fetch timeout
        run_instr(6'h00, 6'h21, 1'b0, TMO - 1, 0);
        run_instr(6'h2b, 6'h00, 1'b0, 1, TMO - 1);

        // Reset in the middle of a lw MEM wait
        void'(plan(6'h23, 6'h00, 1'b0, 0, 3));
        repeat (4) step(q.pop_front(), 6'h23, 6'h00);
        q.delete();
        do_reset();

        for (int n = 0; n < 300; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0, 8: begin op = 6'h00; fn = rfn[$urandom_range(0, 12)]; end
                1: op = 6'h02;
                2: op = 6'h03;
                3: op = 6'h04;
                4: op = iops[$urandom_range(0, 5)];
                5: op = 6'h23;
                6: op = 6'h2b;
                7: begin op = 6'h00; fn = 6'h08 | 6'($urandom_range(0, 1)); end
                default: begin
                    op = 6'($urandom);
                    if (classify(op, fn) != K_ILL) op = 6'h3f;
                end
            endcase
            run_instr(op, fn, rb(), rwait(), rwait());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
